// File: rtl/instr_decode_stage_pkg.sv
// Shared decode definitions: format codes, LEGv8 opcode constants and the
// width of one packed decoded entry.
package instr_decode_stage_pkg;

  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_I  = 3'd1,
    FMT_D  = 3'd2,
    FMT_B  = 3'd3,
    FMT_CB = 3'd4,
    FMT_IW = 3'd5
  } fmt_e;

  // R-format opcodes, instr[31:21]
  localparam logic [10:0] OP_ADD  = 11'b100_0101_1000;
  localparam logic [10:0] OP_ADDS = 11'b101_0101_1000;
  localparam logic [10:0] OP_SUB  = 11'b110_0101_1000;
  localparam logic [10:0] OP_SUBS = 11'b111_0101_1000;
  localparam logic [10:0] OP_AND  = 11'b100_0101_0000;
  localparam logic [10:0] OP_ANDS = 11'b111_0101_0000;
  localparam logic [10:0] OP_ORR  = 11'b101_0101_0000;
  localparam logic [10:0] OP_EOR  = 11'b110_0101_0000;
  localparam logic [10:0] OP_LSL  = 11'b110_1001_1011;
  localparam logic [10:0] OP_LSR  = 11'b110_1001_1010;
  localparam logic [10:0] OP_BR   = 11'b110_1011_0000;
  localparam logic [10:0] OP_MUL  = 11'b100_1101_1000;

  // I-format opcodes, instr[31:22]
  localparam logic [9:0] OP_ADDI  = 10'b10_0100_0100;
  localparam logic [9:0] OP_ADDIS = 10'b10_1100_0100;
  localparam logic [9:0] OP_SUBI  = 10'b11_0100_0100;
  localparam logic [9:0] OP_SUBIS = 10'b11_1100_0100;
  localparam logic [9:0] OP_ANDI  = 10'b10_0100_1000;
  localparam logic [9:0] OP_ANDIS = 10'b11_1100_1000;
  localparam logic [9:0] OP_ORRI  = 10'b10_1100_1000;
  localparam logic [9:0] OP_EORI  = 10'b11_0100_1000;

  // D-format opcodes, instr[31:21]
  localparam logic [10:0] OP_LDUR   = 11'b111_1100_0010;
  localparam logic [10:0] OP_STUR   = 11'b111_1100_0000;
  localparam logic [10:0] OP_LDURSW = 11'b101_1100_0100;
  localparam logic [10:0] OP_STURW  = 11'b101_1100_0000;
  localparam logic [10:0] OP_LDURH  = 11'b011_1100_0010;
  localparam logic [10:0] OP_STURH  = 11'b011_1100_0000;
  localparam logic [10:0] OP_LDURB  = 11'b001_1100_0010;
  localparam logic [10:0] OP_STURB  = 11'b001_1100_0000;

  // illegal + format + opcode + rm/rn/rd + imm + pc
  function automatic int unsigned entry_width(input int unsigned dw, input int unsigned pw);
    return 1 + 3 + 11 + 15 + dw + pw;
  endfunction

endpackage

// File: rtl/instr_decode_stage_classify.sv
// Combinational LEGv8 classifier: format, register fields, extended immediate
// and illegal-opcode flag for one instruction.
module instr_classify
  import instr_decode_stage_pkg::*;
#(
  parameter int unsigned INSTR_LEN  = 32,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic [INSTR_LEN-1:0]  instr,
  output logic [2:0]            format,
  output logic [10:0]           opcode,
  output logic [4:0]            rm,
  output logic [4:0]            rn,
  output logic [4:0]            rd,
  output logic [DATA_WIDTH-1:0] imm,
  output logic                  illegal
);

  fmt_e fmt;

  assign opcode = instr[31:21];
  assign rm     = instr[20:16];
  assign rn     = instr[9:5];
  assign rd     = instr[4:0];
  assign format = fmt;

  // Priority classification, first match wins; illegal forces R with zero imm
  always_comb begin
    fmt     = FMT_R;
    imm     = '0;
    illegal = 1'b0;
    if (instr[31:26] inside {6'b000101, 6'b100101}) begin
      fmt = FMT_B;
      imm = DATA_WIDTH'($signed(instr[25:0])) << 2;
    end else if (instr[31:24] inside {8'b10110100, 8'b10110101, 8'b01010100}) begin
      fmt = FMT_CB;
      imm = DATA_WIDTH'($signed(instr[23:5])) << 2;
    end else if (instr[31:23] inside {9'b110100101, 9'b111100101}) begin
      fmt = FMT_IW;
      imm = DATA_WIDTH'(instr[20:5]) << {instr[22:21], 4'b0000};
      // A 32-bit immediate has no room for shifts of 32 or 48
      if (DATA_WIDTH == 32 && instr[22]) illegal = 1'b1;
    end else if (instr[31:22] inside {OP_ADDI, OP_ADDIS, OP_SUBI, OP_SUBIS,
                                      OP_ANDI, OP_ANDIS, OP_ORRI, OP_EORI}) begin
      fmt = FMT_I;
      imm = DATA_WIDTH'(instr[21:10]);
    end else if (instr[31:21] inside {OP_LDUR, OP_STUR, OP_LDURSW, OP_STURW,
                                      OP_LDURH, OP_STURH, OP_LDURB, OP_STURB}) begin
      fmt = FMT_D;
      imm = DATA_WIDTH'($signed(instr[20:12]));
    end else if (instr[31:21] inside {OP_ADD, OP_ADDS, OP_SUB, OP_SUBS, OP_AND, OP_ANDS,
                                      OP_ORR, OP_EOR, OP_LSL, OP_LSR, OP_BR, OP_MUL}) begin
      fmt = FMT_R;
      imm = DATA_WIDTH'(instr[15:10]);
    end else begin
      illegal = 1'b1;
    end
    if (illegal) begin
      fmt = FMT_R;
      imm = '0;
    end
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage: classifies accepted instructions at push time and
// buffers up to BUF_DEPTH decoded entries toward execute, with flush.
module instr_decode_stage
  import instr_decode_stage_pkg::*;
#(
  parameter int unsigned INSTR_LEN  = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned PC_WIDTH   = 64,
  parameter int unsigned BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INSTR_LEN-1:0]  in_instr,
  input  logic [PC_WIDTH-1:0]   in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2:0]            out_format,
  output logic [10:0]           out_opcode,
  output logic [4:0]            out_rm,
  output logic [4:0]            out_rn,
  output logic [4:0]            out_rd,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic                  out_illegal
);

  localparam int unsigned EW    = entry_width(DATA_WIDTH, PC_WIDTH);
  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  logic [2:0]            c_format;
  logic [10:0]           c_opcode;
  logic [4:0]            c_rm, c_rn, c_rd;
  logic [DATA_WIDTH-1:0] c_imm;
  logic                  c_illegal;
  logic [EW-1:0]         entry;

  logic [EW-1:0]    mem [BUF_DEPTH];
  logic [PTR_W-1:0] head_ptr, tail_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop;

  instr_classify #(
    .INSTR_LEN (INSTR_LEN),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_classify (
    .instr  (in_instr),
    .format (c_format),
    .opcode (c_opcode),
    .rm     (c_rm),
    .rn     (c_rn),
    .rd     (c_rd),
    .imm    (c_imm),
    .illegal(c_illegal)
  );

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign entry     = {c_illegal, c_format, c_opcode, c_rm, c_rn, c_rd, c_imm, in_pc};
  assign in_ready  = (count < CNT_W'(BUF_DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  // Head entry drives the outputs directly; storage is zeroed on reset so
  // the data outputs read 0 afterwards
  assign {out_illegal, out_format, out_opcode, out_rm, out_rn, out_rd,
          out_imm, out_pc} = mem[head_ptr];

  // FIFO pointers, occupancy and storage
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      head_ptr <= '0;
      tail_ptr <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count    <= '0;
      head_ptr <= '0;
      tail_ptr <= '0;
    end else begin
      if (push) begin
        mem[tail_ptr] <= entry;
        tail_ptr      <= next_ptr(tail_ptr);
      end
      if (pop) head_ptr <= next_ptr(head_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
